jk_cmd_sequencer: RTL

- Command-driven excitation generator that sits directly upstream of a bank of WIDTH JK flip-flops and drives their J/K inputs.
- Accepts one command at a time over a valid/ready handshake. Commands are load, set/clear/toggle under a mask, or up/down count for N steps.
- Translates each command into per-cycle J/K excitation.
- Keeps a shadow copy of the expected bank state, so excitation never waits on the bank's Q feedback.

---
 rtl/jk_cmd_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command-driven J/K excitation generator for a bank of WIDTH JK flip-flops.
// Optional Q-vs-shadow consistency check enabled by defining JK_SEQ_CHECK_EN.
module jk_cmd_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] shadow
`ifdef JK_SEQ_CHECK_EN
  ,
  output logic             mismatch
`endif
);

  localparam int unsigned OP_W = 3;
  localparam logic [OP_W-1:0] OP_HOLD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SET    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_CLEAR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_TOGGLE = OP_W'(4);
  localparam logic [OP_W-1:0] OP_CNT_UP = OP_W'(5);
  localparam logic [OP_W-1:0] OP_CNT_DN = OP_W'(6);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic             count_up;
  logic             err_pend;
  logic [WIDTH-1:0] shadow_nxt;
  logic [WIDTH-1:0] up_ex;
  logic [WIDTH-1:0] dn_ex;
  logic             carry_up;
  logic             carry_dn;
  logic             mis_nxt;

  // Shadow follows the JK next-state rule using the excitation being presented,
  // and count excitation is derived from the value the bank holds after this edge.
  always_comb begin
    shadow_nxt = (j & ~shadow) | (~k & shadow);
    up_ex      = '0;
    dn_ex      = '0;
    carry_up   = 1'b1;
    carry_dn   = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      up_ex[i] = carry_up;
      dn_ex[i] = carry_dn;
      carry_up = carry_up & shadow_nxt[i];
      carry_dn = carry_dn & ~shadow_nxt[i];
    end
  end

`ifdef JK_SEQ_CHECK_EN
  assign mis_nxt = mismatch | (q != shadow);
`else
  logic unused_q;
  assign mis_nxt  = 1'b0;
  assign unused_q = ^q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      j         <= '0;
      k         <= '0;
      shadow    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
      remain    <= '0;
      count_up  <= 1'b0;
      err_pend  <= 1'b0;
`ifdef JK_SEQ_CHECK_EN
      mismatch  <= 1'b0;
`endif
    end else begin
      shadow <= shadow_nxt;
      done   <= 1'b0;
      err    <= 1'b0;
`ifdef JK_SEQ_CHECK_EN
      mismatch <= mis_nxt;
`endif
      unique case (state)
        ST_IDLE: begin
          j <= '0;
          k <= '0;
          if (cmd_valid && cmd_ready) begin
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            err_pend  <= 1'b0;
            state     <= ST_STEP;
            case (cmd_op)
              OP_HOLD: ;
              OP_LOAD: begin
                j <= cmd_data;
                k <= ~cmd_data;
              end
              OP_SET:    j <= cmd_data;
              OP_CLEAR:  k <= cmd_data;
              OP_TOGGLE: begin
                j <= cmd_data;
                k <= cmd_data;
              end
              OP_CNT_UP, OP_CNT_DN: begin
                count_up <= (cmd_op == OP_CNT_UP);
                // A zero-length count degenerates to a single HOLD step
                if (cmd_len != '0) begin
                  state  <= ST_RUN;
                  remain <= cmd_len - LEN_W'(1);
                  j      <= (cmd_op == OP_CNT_UP) ? up_ex : dn_ex;
                  k      <= (cmd_op == OP_CNT_UP) ? up_ex : dn_ex;
                end
              end
              default: err_pend <= 1'b1;
            endcase
          end
        end
        ST_STEP, ST_RUN: begin
          if (state == ST_RUN && remain != '0) begin
            remain <= remain - LEN_W'(1);
            j      <= count_up ? up_ex : dn_ex;
            k      <= count_up ? up_ex : dn_ex;
          end else begin
            state     <= ST_IDLE;
            j         <= '0;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            err       <= err_pend;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (mis_nxt) cmd_ready <= 1'b0;
    end
  end

endmodule
